// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for the sprite and colour-mapping stages that
//   follow it. The free-running horizontal and vertical counters are exposed
//   directly as DrawX/DrawY. The hs/vs/blank decode is delayed by SYNC_DELAY
//   clocks, so the sync pulses stay aligned with pixels leaving the colour
//   path (ROM read plus output register). A once-per-frame tick and a frame
//   counter feed the game-state update logic.
//
// Ports
//   vga_clk      in   pixel clock, the only clock
//   reset        in   synchronous active-high reset
//   DrawX[9:0]   out  horizontal counter, 0..H_TOTAL-1
//   DrawY[9:0]   out  vertical counter, 0..V_TOTAL-1
//   blank        out  1 = visible pixel, delayed SYNC_DELAY clocks
//   hs           out  horizontal sync, active-low, delayed SYNC_DELAY clocks
//   vs           out  vertical sync, active-low, delayed SYNC_DELAY clocks
//   frame_tick   out  one-clock pulse while (DrawX,DrawY) = (0,V_VISIBLE)
//   frame_count  out  number of frame_tick pulses since reset, wrapping
//
// H_TOTAL and V_TOTAL must each be <= 1024. SYNC_DELAY is legal in 0..4.

module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);

    // The decode compares use 11 bits so that a sync window ending exactly
    // at 1024 (zero back porch with a full 1024 total) still compares correctly.
    localparam logic [10:0] H_VIS_W    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_W    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START_W = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END_W   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START_W = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END_W   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-line idle value, ordered as {blank, hs, vs}.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [9:0]  hc_next;
    logic [9:0]  vc_next;
    logic [10:0] hc_w;
    logic [10:0] vc_w;
    logic        tick_next;
    logic        frame_tick_q;
    logic [15:0] frame_count_q;
    logic        blank_raw;
    logic        hs_raw;
    logic        vs_raw;

    always_comb begin
        hc_next = hc + 10'd1;
        vc_next = vc;
        if (hc == H_MAX) begin
            hc_next = '0;
            vc_next = (vc == V_MAX) ? '0 : vc + 10'd1;
        end
    end

    // frame_tick is a registered output. It is therefore computed from the
    // next counter state, so the pulse lines up with the (0, V_VISIBLE) cycle.
    assign tick_next = (hc_next == '0) && (vc_next == V_VIS);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc           <= '0;
            vc           <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            hc           <= hc_next;
            vc           <= vc_next;
            frame_tick_q <= tick_next;
        end
    end

    // The count advances on the same edge that raises frame_tick. While the
    // pulse is high, the count already includes that frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (tick_next) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign hc_w = {1'b0, hc};
    assign vc_w = {1'b0, vc};

    assign blank_raw = (hc_w < H_VIS_W) && (vc_w < V_VIS_W);
    assign hs_raw    = !((hc_w >= HS_START_W) && (hc_w < HS_END_W));
    assign vs_raw    = !((vc_w >= VS_START_W) && (vc_w < VS_END_W));

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign blank = blank_raw;
            assign hs    = hs_raw;
            assign vs    = vs_raw;
        end else begin : g_delay
            logic [2:0] sync_pipe [SYNC_DELAY];

            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        sync_pipe[i] <= SYNC_IDLE;
                    end
                end else begin
                    sync_pipe[0] <= {blank_raw, hs_raw, vs_raw};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        sync_pipe[i] <= sync_pipe[i-1];
                    end
                end
            end

            assign {blank, hs, vs} = sync_pipe[SYNC_DELAY-1];
        end
    endgenerate

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (32 x 19 clocks per frame)
// so that several full frames and random reset points fit in a short run.
// The reference model works from the number of clocks since reset release.
// From that count it derives the counters with div/mod, and it applies the
// pipeline delay by evaluating the decode SYNC_DELAY clocks in the past.
// A second instance with SYNC_DELAY=0 covers the passthrough build.

module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int D  = 2;
    localparam int FRAME = HT * VT;

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  DrawX, DrawY;
    logic        blank, hs, vs, frame_tick;
    logic [15:0] frame_count;
    logic [9:0]  DrawX0, DrawY0;
    logic        blank0, hs0, vs0, frame_tick0;
    logic [15:0] frame_count0;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_DELAY(D)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .hs(hs), .vs(vs), .frame_tick(frame_tick),
        .frame_count(frame_count)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_DELAY(0)
    ) dut0 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX0), .DrawY(DrawY0),
        .blank(blank0), .hs(hs0), .vs(vs0), .frame_tick(frame_tick0),
        .frame_count(frame_count0)
    );

    always #5 vga_clk = ~vga_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          t       = 0;     // clocks since reset release
    logic [15:0] fc_m    = '0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic int m_h(input int tt);
        return tt % HT;
    endfunction

    function automatic int m_v(input int tt);
        return (tt / HT) % VT;
    endfunction

    function automatic logic m_blank(input int tt);
        return (m_h(tt) < HV) && (m_v(tt) < VV);
    endfunction

    function automatic logic m_hs(input int tt);
        return !((m_h(tt) >= HV + HF) && (m_h(tt) < HV + HF + HS));
    endfunction

    function automatic logic m_vs(input int tt);
        return !((m_v(tt) >= VV + VF) && (m_v(tt) < VV + VF + VS));
    endfunction

    function automatic logic m_tick(input int tt);
        return (m_h(tt) == 0) && (m_v(tt) == VV);
    endfunction

    task automatic check_outputs();
        check_val("drawx", 32'(DrawX), 32'(m_h(t)));
        check_val("drawy", 32'(DrawY), 32'(m_v(t)));
        check_val("blank", 32'(blank), (t < D) ? 32'd0 : 32'(m_blank(t - D)));
        check_val("hs",    32'(hs),    (t < D) ? 32'd1 : 32'(m_hs(t - D)));
        check_val("vs",    32'(vs),    (t < D) ? 32'd1 : 32'(m_vs(t - D)));
        check_val("frame_tick",  32'(frame_tick), 32'(m_tick(t)));
        check_val("frame_count", 32'(frame_count), 32'(fc_m));
        check_val("d0_blank", 32'(blank0), 32'(m_blank(t)));
        check_val("d0_hs",    32'(hs0),    32'(m_hs(t)));
        check_val("d0_vs",    32'(vs0),    32'(m_vs(t)));
    endtask

    // Drive reset for the next edge, advance the model across that edge,
    // then check the outputs on the falling edge.
    task automatic step(input logic rst);
        reset = rst;
        @(posedge vga_clk);
        if (rst) begin
            t    = 0;
            fc_m = '0;
        end else begin
            t++;
            if (m_tick(t)) fc_m = fc_m + 16'd1;
        end
        @(negedge vga_clk);
        check_outputs();
    endtask

    logic seen_wrap;

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1);

        for (int i = 0; i < 3 * FRAME + 50; i++) step(1'b0);

        for (int seg = 0; seg < 10; seg++) begin
            int run_len;
            int rst_len;
            run_len = int'($urandom_range(1, FRAME + HT));
            rst_len = int'($urandom_range(1, 3));
            for (int i = 0; i < run_len; i++) step(1'b0);
            for (int i = 0; i < rst_len; i++) step(1'b1);
        end

        for (int i = 0; i < 40; i++) step(1'b0);
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        fc_m = 16'hFFFF;
        seen_wrap = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            step(1'b0);
            if (frame_tick === 1'b1 && frame_count === 16'h0000) seen_wrap = 1'b1;
        end
        check_val("fc_wrap_seen", 32'(seen_wrap), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that drives the sprite/colour-mapping stages directly downstream.
- Produces the DrawX/DrawY pixel coordinates and the active-video qualifier blank.
- Also produces the hs/vs sync pulses, delayed so they stay aligned with the 2-cycle downstream colour path (ROM read plus output register).
- Supplies a once-per-frame vblank tick and a frame counter for game-state update logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, in clocks
- H_SYNC, 96, hsync pulse width, in clocks
- H_BACK, 48, horizontal back porch; H_TOTAL = sum of the four horizontal parameters = 800
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BACK, 33, vertical back porch; V_TOTAL = sum of the four vertical parameters = 525
- SYNC_DELAY, 2, pipeline depth applied to hs/vs/blank (legal range 0..4)

Ports:
- vga_clk  input  1  pixel clock; the only clock
- reset  input  1  synchronous, active-high reset
- DrawX  output  10  current horizontal counter (hc), 0..H_TOTAL-1
- DrawY  output  10  current vertical counter (vc), 0..V_TOTAL-1
- blank  output  1  active video (1 = visible pixel), delayed SYNC_DELAY cycles
- hs  output  1  horizontal sync, active-low, delayed SYNC_DELAY cycles
- vs  output  1  vertical sync, active-low, delayed SYNC_DELAY cycles
- frame_tick  output  1  one-cycle pulse at the start of vblank, undelayed
- frame_count  output  16  number of frame_tick pulses since reset, wrapping

Behaviour:
- Reset, sampled on the vga_clk rising edge, forces:
  - hc=0, vc=0
  - every delay-line stage to the idle value: hs=1, vs=1, blank=0
  - frame_tick=0, frame_count=0
- Reset asserted mid-frame: on the next clock the counters read (0,0) and the delay line holds idle. There is no partial-frame carry-over.
- Counters:
  - hc increments every clock; wraps H_TOTAL-1 -> 0.
  - vc increments only on the clock where hc==H_TOTAL-1; wraps V_TOTAL-1 -> 0 when hc and vc are both at their maxima (same clock).
- DrawX=hc and DrawY=vc, driven directly from the counter registers (0 extra latency).
- Raw (undelayed) signals, decoded from hc/vc:
  - blank_raw = (hc < H_VISIBLE) && (vc < V_VISIBLE)
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751 at defaults)
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491 at defaults)
  - vs_raw follows vc only; it changes on line boundaries.
- Delay line:
  - hs/vs/blank equal the raw values from exactly SYNC_DELAY clocks earlier, via a shift register reset to idle.
  - SYNC_DELAY=0 means combinational passthrough of the raw decode.
- After reset release, the first visible blank=1 appears SYNC_DELAY clocks after DrawX=0,DrawY=0 is first presented.
- frame_tick: 1 for exactly one clock when hc==0 && vc==V_VISIBLE; 0 otherwise.
- frame_count: increments by 1 on the same edge that frame_tick is high; wraps 0xFFFF -> 0x0000.
- All outputs are registered except the decode path when SYNC_DELAY=0. There is no dependency on input data other than reset.
- Width rule: counters are 10 bits; parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024.

Test Plan:
- Assert reset 3 clocks, release -> DrawX/DrawY=0/0, hs=vs=1, blank=0, frame_count=0. Next clock DrawX=1. blank=1 first seen 2 clocks after the DrawX=0 cycle.
- Run to hc=799, vc=5 -> next clock DrawX=0, DrawY=6. At hc=799, vc=524 -> next clock 0,0, with no frame_tick on that wrap.
- Observe one line -> hs low for exactly 96 consecutive clocks, first low on the clock 2 cycles after DrawX=656. blank high for 640 clocks on visible lines and 0 on line 480+.
- Observe full frame -> vs low for exactly 1600 clocks (2 lines), starting 2 clocks after DrawX=0, DrawY=490. frame_tick pulses once per 420000 clocks, at DrawX=0, DrawY=480.
- Reset mid-frame at DrawX=300, DrawY=200 -> next clock 0,0; hs=vs=1, blank=0 for 2 clocks; frame_count=0.
- Preload frame_count to 0xFFFF (force), reach vblank -> frame_tick=1 and frame_count becomes 0x0000 on that edge.
